// File: rtl/button_counter_if.sv
// Signal bundle between the button counter and whatever drives its buttons
// and watches its LEDs. The clock and reset stay outside as plain ports.
`timescale 1ns/1ps

interface button_counter_if #(
    parameter int WIDTH = 8
);
    logic             i_Button_Up;
    logic             i_Button_Down;
    logic             i_Load;
    logic [WIDTH-1:0] i_Load_Value;
    logic [WIDTH-1:0] o_LED;
    logic             o_Wrap;

    // Board / stimulus side: drives the buttons and load, observes the LEDs.
    modport master (
        output i_Button_Up,
        output i_Button_Down,
        output i_Load,
        output i_Load_Value,
        input  o_LED,
        input  o_Wrap
    );

    // Counter side.
    modport slave (
        input  i_Button_Up,
        input  i_Button_Down,
        input  i_Load,
        input  i_Load_Value,
        output o_LED,
        output o_Wrap
    );
endinterface

// File: rtl/button_counter.sv
// Push-button event counter driving an LED bank.
// Each raw button is synchronised (2 flops), debounced over DEBOUNCE_CYCLES
// stable cycles and edge-detected; a press steps a modulo-(MAX_COUNT+1)
// counter that drives the LEDs directly. o_Wrap pulses for one cycle on wrap.
// Build option: define BUTTON_COUNTER_DOWN_EN to build the down-button
// channel; without it the counter is up-only and i_Button_Down is ignored.
`timescale 1ns/1ps

module button_counter #(
    parameter int WIDTH           = 8,
    parameter int MAX_COUNT       = (2 ** WIDTH) - 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    button_counter_if.slave    bus
);

`ifdef BUTTON_COUNTER_DOWN_EN
    localparam int NUM_CH = 2;
`else
    localparam int NUM_CH = 1;
`endif

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);

    // Channel 0 is the up button; channel 1 (when built) is the down button.
    logic [NUM_CH-1:0] raw_btn;
    logic [NUM_CH-1:0] press;

    assign raw_btn[0] = bus.i_Button_Up;
`ifdef BUTTON_COUNTER_DOWN_EN
    assign raw_btn[1] = bus.i_Button_Down;
`else
    logic unused_down;
    assign unused_down = bus.i_Button_Down;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Synchronise the raw button, then accept a level change only once
            // the synchronised level has differed for DEBOUNCE_CYCLES cycles.
            always_ff @(posedge i_Clk) begin
                if (i_Reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_btn[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            // A press is flagged in the same cycle the debounced level is
            // about to rise, so the counter steps on that very edge.
            assign press[gi] = sync2_reg && !level_reg && (cnt_reg == CNT_LAST);
        end
    endgenerate

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;

    // Next count: load beats presses; presses step with wrap at the ends.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (bus.i_Load) begin
            count_next = (bus.i_Load_Value > MAX_VAL) ? MAX_VAL : bus.i_Load_Value;
`ifdef BUTTON_COUNTER_DOWN_EN
        end else if (press[0] && !press[1]) begin
`else
        end else if (press[0]) begin
`endif
            if (count_reg == MAX_VAL) begin
                count_next = '0;
                wrap_next  = 1'b1;
            end else begin
                count_next = count_reg + WIDTH'(1);
            end
`ifdef BUTTON_COUNTER_DOWN_EN
        end else if (press[1] && !press[0]) begin
            if (count_reg == '0) begin
                count_next = MAX_VAL;
                wrap_next  = 1'b1;
            end else begin
                count_next = count_reg - WIDTH'(1);
            end
`endif
        end
    end

    // Count and wrap-pulse registers; both outputs come straight from flops.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign bus.o_LED  = count_reg;
    assign bus.o_Wrap = wrap_reg;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter with WIDTH=8, MAX_COUNT=9,
// DEBOUNCE_CYCLES=4. Down-button scenarios follow BUTTON_COUNTER_DOWN_EN.
`timescale 1ns/1ps

module tb_button_counter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    button_counter_if #(.WIDTH(8)) bus ();

    button_counter #(
        .WIDTH           (8),
        .MAX_COUNT       (9),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 ns past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_Button_Up   = 1'b0;
        bus.i_Button_Down = 1'b0;
        bus.i_Load        = 1'b0;
        bus.i_Load_Value  = '0;
        rst = 1'b1;
        tick(3);
        checks++;
        if (bus.o_LED !== 8'd0) begin
            errors++; $display("FAIL reset_led: got %0d expected 0", bus.o_LED);
        end
        checks++;
        if (bus.o_Wrap !== 1'b0) begin
            errors++; $display("FAIL reset_wrap: got %b expected 0", bus.o_Wrap);
        end
        rst = 1'b0;
        tick(4);
        $display("reset: led=%0d wrap=%b", bus.o_LED, bus.o_Wrap);
    endtask

    // Up held high: first edge seeing it high is k, count moves at k+5.
    task automatic test_hold();
        int wraps;
        int changes;
        wraps = 0;
        changes = 0;
        bus.i_Button_Up = 1'b1;
        tick(5);
        checks++;
        if (bus.o_LED !== 8'd0) begin
            errors++; $display("FAIL hold_early: got %0d expected 0", bus.o_LED);
        end
        tick(1);
        checks++;
        if (bus.o_LED !== 8'd1) begin
            errors++; $display("FAIL hold_latency: got %0d expected 1", bus.o_LED);
        end
        checks++;
        if (bus.o_Wrap !== 1'b0) begin
            errors++; $display("FAIL hold_wrap: got %b expected 0", bus.o_Wrap);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.o_Wrap === 1'b1) wraps++;
            if (bus.o_LED !== 8'd1) changes++;
        end
        checks++;
        if (changes != 0 || wraps != 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d changes %0d wraps expected 0 0", changes, wraps);
        end
        bus.i_Button_Up = 1'b0;
        tick(8);
        $display("hold: led=%0d", bus.o_LED);
    endtask

    // Bounce of 2 cycles per level never reaches the 4-cycle threshold.
    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.i_Button_Up = ~bus.i_Button_Up;
            tick(2);
        end
        bus.i_Button_Up = 1'b0;
        tick(10);
        checks++;
        if (bus.o_LED !== 8'd0) begin
            errors++; $display("FAIL bounce: got %0d expected 0", bus.o_LED);
        end
        $display("bounce: led=%0d", bus.o_LED);
    endtask

    // Ten clean presses walk 1..9 then wrap to 0 with a single wrap pulse.
    task automatic test_up_wrap();
        int exp_led;
        int late_wraps;
        late_wraps = 0;
        do_reset();
        for (int p = 1; p <= 10; p++) begin
            exp_led = p % 10;
            bus.i_Button_Up = 1'b1;
            tick(6);
            checks++;
            if (bus.o_LED !== exp_led[7:0]) begin
                errors++; $display("FAIL up_press%0d: got %0d expected %0d", p, bus.o_LED, exp_led);
            end
            checks++;
            if (bus.o_Wrap !== (exp_led == 0)) begin
                errors++; $display("FAIL up_wrap%0d: got %b expected %b", p, bus.o_Wrap, exp_led == 0);
            end
            for (int c = 0; c < 10; c++) begin
                if (c == 2) bus.i_Button_Up = 1'b0;
                tick(1);
                if (bus.o_Wrap === 1'b1) late_wraps++;
            end
            $display("up press %0d: led=%0d wrap=%b", p, bus.o_LED, bus.o_Wrap);
        end
        checks++;
        if (late_wraps != 0) begin
            errors++; $display("FAIL wrap_one_cycle: got %0d extra wrap cycles expected 0", late_wraps);
        end
    endtask

    task automatic test_down();
        do_reset();
`ifdef BUTTON_COUNTER_DOWN_EN
        bus.i_Button_Down = 1'b1;
        tick(5);
        checks++;
        if (bus.o_LED !== 8'd0) begin
            errors++; $display("FAIL down_early: got %0d expected 0", bus.o_LED);
        end
        tick(1);
        checks++;
        if (bus.o_LED !== 8'd9) begin
            errors++; $display("FAIL down_wrap_led: got %0d expected 9", bus.o_LED);
        end
        checks++;
        if (bus.o_Wrap !== 1'b1) begin
            errors++; $display("FAIL down_wrap_pulse: got %b expected 1", bus.o_Wrap);
        end
        tick(1);
        checks++;
        if (bus.o_Wrap !== 1'b0) begin
            errors++; $display("FAIL down_wrap_end: got %b expected 0", bus.o_Wrap);
        end
        bus.i_Button_Down = 1'b0;
        tick(8);
        $display("down press: led=%0d", bus.o_LED);
        // Plain decrement away from the boundary.
        bus.i_Button_Down = 1'b1;
        tick(6);
        checks++;
        if (bus.o_LED !== 8'd8) begin
            errors++; $display("FAIL down_step: got %0d expected 8", bus.o_LED);
        end
        bus.i_Button_Down = 1'b0;
        tick(8);
        $display("down press: led=%0d", bus.o_LED);
        // Both buttons with identical timing cancel.
        bus.i_Button_Up   = 1'b1;
        bus.i_Button_Down = 1'b1;
        tick(6);
        checks++;
        if (bus.o_LED !== 8'd8 || bus.o_Wrap !== 1'b0) begin
            errors++; $display("FAIL both_press: got led=%0d wrap=%b expected led=8 wrap=0", bus.o_LED, bus.o_Wrap);
        end
        tick(4);
        checks++;
        if (bus.o_LED !== 8'd8) begin
            errors++; $display("FAIL both_hold: got %0d expected 8", bus.o_LED);
        end
        bus.i_Button_Up   = 1'b0;
        bus.i_Button_Down = 1'b0;
        tick(8);
        $display("up+down press: led=%0d", bus.o_LED);
`else
        bus.i_Button_Down = 1'b1;
        tick(10);
        checks++;
        if (bus.o_LED !== 8'd0 || bus.o_Wrap !== 1'b0) begin
            errors++; $display("FAIL down_ignored: got led=%0d wrap=%b expected led=0 wrap=0", bus.o_LED, bus.o_Wrap);
        end
        bus.i_Button_Down = 1'b0;
        tick(8);
        $display("down press (no down channel): led=%0d", bus.o_LED);
        // Without the down channel an up press with down held still counts.
        bus.i_Button_Up   = 1'b1;
        bus.i_Button_Down = 1'b1;
        tick(6);
        checks++;
        if (bus.o_LED !== 8'd1) begin
            errors++; $display("FAIL up_only_both: got %0d expected 1", bus.o_LED);
        end
        bus.i_Button_Up   = 1'b0;
        bus.i_Button_Down = 1'b0;
        tick(8);
        $display("up+down press (no down channel): led=%0d", bus.o_LED);
`endif
    endtask

    task automatic test_load();
        do_reset();
        // Oversized value saturates to MAX_COUNT after one edge.
        bus.i_Load       = 1'b1;
        bus.i_Load_Value = 8'd200;
        tick(1);
        bus.i_Load = 1'b0;
        checks++;
        if (bus.o_LED !== 8'd9 || bus.o_Wrap !== 1'b0) begin
            errors++; $display("FAIL load_clamp: got led=%0d wrap=%b expected led=9 wrap=0", bus.o_LED, bus.o_Wrap);
        end
        $display("load 200: led=%0d", bus.o_LED);
        // Up press from the loaded terminal count wraps.
        bus.i_Button_Up = 1'b1;
        tick(6);
        checks++;
        if (bus.o_LED !== 8'd0 || bus.o_Wrap !== 1'b1) begin
            errors++; $display("FAIL load_then_wrap: got led=%0d wrap=%b expected led=0 wrap=1", bus.o_LED, bus.o_Wrap);
        end
        bus.i_Button_Up = 1'b0;
        tick(8);
        // In-range load.
        bus.i_Load       = 1'b1;
        bus.i_Load_Value = 8'd5;
        tick(1);
        bus.i_Load = 1'b0;
        checks++;
        if (bus.o_LED !== 8'd5) begin
            errors++; $display("FAIL load_value: got %0d expected 5", bus.o_LED);
        end
        $display("load 5: led=%0d", bus.o_LED);
        // Load on the very edge a press is accepted: the press is dropped.
        bus.i_Button_Up = 1'b1;
        tick(5);
        bus.i_Load       = 1'b1;
        bus.i_Load_Value = 8'd3;
        tick(1);
        bus.i_Load = 1'b0;
        checks++;
        if (bus.o_LED !== 8'd3 || bus.o_Wrap !== 1'b0) begin
            errors++; $display("FAIL load_vs_press: got led=%0d wrap=%b expected led=3 wrap=0", bus.o_LED, bus.o_Wrap);
        end
        tick(6);
        checks++;
        if (bus.o_LED !== 8'd3) begin
            errors++; $display("FAIL load_press_dropped: got %0d expected 3", bus.o_LED);
        end
        bus.i_Button_Up = 1'b0;
        tick(8);
        $display("load 3 with press: led=%0d", bus.o_LED);
    endtask

    // Reset mid-debounce, with the button still held at release.
    task automatic test_reset_mid();
        bus.i_Load       = 1'b1;
        bus.i_Load_Value = 8'd4;
        tick(1);
        bus.i_Load = 1'b0;
        bus.i_Button_Up = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        checks++;
        if (bus.o_LED !== 8'd0 || bus.o_Wrap !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got led=%0d wrap=%b expected led=0 wrap=0", bus.o_LED, bus.o_Wrap);
        end
        rst = 1'b0;
        tick(5);
        checks++;
        if (bus.o_LED !== 8'd0) begin
            errors++; $display("FAIL release_early: got %0d expected 0", bus.o_LED);
        end
        tick(1);
        checks++;
        if (bus.o_LED !== 8'd1) begin
            errors++; $display("FAIL release_press: got %0d expected 1", bus.o_LED);
        end
        tick(10);
        checks++;
        if (bus.o_LED !== 8'd1) begin
            errors++; $display("FAIL release_hold: got %0d expected 1", bus.o_LED);
        end
        bus.i_Button_Up = 1'b0;
        tick(8);
        $display("reset mid-press: led=%0d", bus.o_LED);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_hold();
        test_bounce();
        test_up_wrap();
        test_down();
        test_load();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
